de2_115_qsys_pio_out: RTL
=========================

Name: de2_115_qsys_pio_out

Overview:
- Avalon-MM slave output PIO: the write-side counterpart of the switch input port.
- Drives a WIDTH-bit out_port for LEDs, solenoid and actuator drivers on the pingpong table.
- Supports direct data writes, atomic bit set and bit clear, and a hardware-timed one-shot pulse mask, so software can fire actuators for an exact cycle count.
- Sits in the QSYS system on the CPU data master, same clock domain.

Parameters:
- WIDTH, 8, out_port width; legal range 1..32.
- PULSE_W, 16, width of the pulse length register and the pulse timer.
- PULSE_DEFAULT, 1000, reset value of pulse_len, in clk cycles.
- RESET_VALUE, 0, reset value of data_reg; WIDTH bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select; a write requires chipselect=1 and write_n=0.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH or PULSE_W are ignored.
- readdata  out  32  registered read data; upper bits are zero.
- out_port  out  WIDTH  pin output, equal to data_reg | pulse_mask.

Behaviour:
- Reset (asynchronous, while reset_n=0): data_reg=RESET_VALUE; pulse_mask=0; timer=0; pulse_len=PULSE_DEFAULT; readdata=0; out_port=RESET_VALUE.
- Reset asserted mid-pulse aborts the pulse immediately.
- Register map, write effects (applied at the write's clock edge):
  - addr 0 DATA: data_reg <= writedata[WIDTH-1:0].
  - addr 1 PULSE_LEN: pulse_len <= writedata[PULSE_W-1:0].
  - addr 2 PULSE: if pulse_len!=0, then pulse_mask <= pulse_mask | writedata[WIDTH-1:0] and timer <= pulse_len. If pulse_len==0, the write is ignored.
  - addr 3 STATUS: read-only; writes are ignored.
  - addr 4 OUTSET: data_reg <= data_reg | writedata[WIDTH-1:0].
  - addr 5 OUTCLEAR: data_reg <= data_reg & ~writedata[WIDTH-1:0].
  - addr 6, 7: writes are ignored.
- Read values:
  - addr 0: data_reg.
  - addr 1: pulse_len.
  - addr 2: pulse_mask.
  - addr 3: bit0=busy (timer!=0), bits[PULSE_W+15:16]=timer.
  - addr 4..7: 0.
- readdata is registered every clk cycle from the current address, with no read strobe: 1-cycle read latency. Register contents reflect writes from the previous edge.
- out_port is combinational from registers only, with no path from bus inputs. It changes in the same cycle the updated register becomes visible, i.e. after the write edge.
- Pulse timer state machine, two states:
  - IDLE (timer=0, pulse_mask=0).
  - ACTIVE (timer!=0). Each edge without a PULSE write: if timer==1, then timer <= 0 and pulse_mask <= 0, returning to IDLE; else timer <= timer-1.
  - Result: the mask is high for exactly pulse_len cycles after the write edge.
- Boundary rules:
  - PULSE write while ACTIVE: new bits OR into the mask and the timer reloads to pulse_len, so the whole mask is extended. The write takes priority over decrement and expiry in the same cycle.
  - PULSE_LEN write while ACTIVE: does not affect the running timer; it applies to the next PULSE write only.
  - pulse_len=1: mask high for exactly 1 cycle.
  - Max pulse_len is 2^PULSE_W-1, with no wrap.
  - A pulse bit that is also set in data_reg stays high after expiry, because of the OR.
  - OUTCLEAR does not clear pulse_mask bits.
  - The data path and the pulse path are independent; writes to different registers never occur in the same cycle on a single-port slave.
  - chipselect=0 with write_n=0: no effect.

Test Plan:
- Reset, then read addr 0, 1, 3 -> readdata 0x0, 0x3E8, 0x0, each 1 cycle after the address is applied; out_port=0x00 during and after reset.
- Write DATA=0x1A5 (WIDTH=8); OUTSET 0x40; OUTCLEAR 0x05 -> out_port sequence 0xA5, 0xE5, 0xE0; readback of addr 0 = 0xE0.
- PULSE_LEN=5, PULSE=0x01 -> out_port bit0 high exactly 5 cycles, STATUS busy=1 and timer counting 5..1, then busy=0 and mask 0.
- PULSE_LEN=10, PULSE=0x02; at cycle 4 PULSE=0x04 -> bits 1 and 2 both high until 10 cycles after the second write (14 total for bit1); PULSE_LEN=0 then PULSE=0x08 -> no change.
- DATA=0x01 then PULSE=0x01 with len 3 -> bit0 stays 1 after expiry; reset_n pulsed low mid-pulse -> out_port=RESET_VALUE and busy=0 immediately (asynchronous).
- Write with chipselect=0, and writes to addr 3/6/7 -> no register change; reads of addr 5..7 return 0.

Source files
------------

// File: rtl/de2_115_qsys_pio_out.sv
// Avalon-MM output PIO with direct write, atomic set/clear and a hardware-timed
// one-shot pulse mask OR-ed onto the pin output.
module de2_115_qsys_pio_out #(
   parameter int WIDTH         = 8,
   parameter int PULSE_W       = 16,
   parameter int PULSE_DEFAULT = 1000,
   parameter int RESET_VALUE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [WIDTH-1:0]   DATA_RST = WIDTH'(RESET_VALUE);
   localparam logic [PULSE_W-1:0] LEN_RST  = PULSE_W'(PULSE_DEFAULT);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Status word: busy flag in bit 0, live timer value from bit 16 upward.
   function automatic logic [31:0] status_word(input logic [PULSE_W-1:0] t);
      logic [63:0] w;
      w                = 64'd0;
      w[0]             = (t != '0);
      w[PULSE_W+15:16] = t;
      return w[31:0];
   endfunction

   logic [WIDTH-1:0]   data_q, data_d;
   logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;
   logic [WIDTH-1:0]   mask_q;
   logic [PULSE_W-1:0] timer_q;
   state_t             state_q;
   logic [31:0]        readdata_q, readdata_d;
   logic               wr_s;
   logic               pulse_wr_s;
   logic               unused_wd;

   assign wr_s       = chipselect && !write_n;
   assign pulse_wr_s = wr_s && (address == 3'd2);
   assign unused_wd  = &{1'b0, writedata};

   // Next-state for the data and pulse-length registers.
   always_comb begin
      data_d      = data_q;
      pulse_len_d = pulse_len_q;
      if (wr_s) begin
         case (address)
            3'd0:    data_d      = writedata[WIDTH-1:0];
            3'd1:    pulse_len_d = writedata[PULSE_W-1:0];
            3'd4:    data_d      = data_q | writedata[WIDTH-1:0];
            3'd5:    data_d      = data_q & ~writedata[WIDTH-1:0];
            default: data_d      = data_q;
         endcase
      end else begin
         data_d = data_q;
      end
   end

   // Read mux sampled every cycle; bus sees register values from before this edge.
   always_comb begin
      readdata_d = 32'd0;
      case (address)
         3'd0:    readdata_d = 32'(data_q);
         3'd1:    readdata_d = 32'(pulse_len_q);
         3'd2:    readdata_d = 32'(mask_q);
         3'd3:    readdata_d = status_word(timer_q);
         default: readdata_d = 32'd0;
      endcase
   end

   // Data, pulse length and read-data registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q      <= DATA_RST;
         pulse_len_q <= LEN_RST;
         readdata_q  <= 32'd0;
      end else begin
         data_q      <= data_d;
         pulse_len_q <= pulse_len_d;
         readdata_q  <= readdata_d;
      end
   end

   // Pulse timer: a PULSE write reloads and extends the mask ahead of any expiry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         mask_q  <= '0;
      end else if (pulse_wr_s && (pulse_len_q != '0)) begin
         state_q <= ST_ACTIVE;
         timer_q <= pulse_len_q;
         mask_q  <= mask_q | writedata[WIDTH-1:0];
      end else begin
         case (state_q)
            ST_ACTIVE: begin
               if (timer_q == PULSE_W'(1)) begin
                  state_q <= ST_IDLE;
                  timer_q <= '0;
                  mask_q  <= '0;
               end else begin
                  timer_q <= timer_q - PULSE_W'(1);
               end
            end
            ST_IDLE: begin
               timer_q <= '0;
               mask_q  <= '0;
            end
            default: begin
               state_q <= ST_IDLE;
               timer_q <= '0;
               mask_q  <= '0;
            end
         endcase
      end
   end

   assign readdata = readdata_q;
   assign out_port = data_q | mask_q;

endmodule
